muntjac_ras: RTL and testbench
==============================

MUNTJAC_RAS -- requirements
Module: muntjac_ras

Interface
REQ-001 SHALL have parameter AddrLen, default 64, virtual address width.
REQ-002 SHALL have parameter Depth, default 8, number of stack entries; must be a power of 2 and at least 2.
REQ-003 SHALL have port clk_i, input, 1, clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port pred_valid_i, input, 1, fetch-stage prediction for the current PC is valid (BTB hit).
REQ-006 SHALL have port pred_branch_type_i, input, branch_type_e, predicted branch type from the BTB.
REQ-007 SHALL have port pred_pc_i, input, AddrLen, PC of the predicted control-transfer instruction.
REQ-008 SHALL have port pred_compressed_i, input, 1, predicted instruction is 16-bit.
REQ-009 SHALL have port ret_valid_o, output, 1, stack non-empty, so ret_addr_o is usable.
REQ-010 SHALL have port ret_addr_o, output, AddrLen, speculative top-of-stack return target.
REQ-011 SHALL have port commit_valid_i, input, 1, an instruction retires this cycle.
REQ-012 SHALL have port commit_branch_type_i, input, branch_type_e, actual type of the retiring instruction.
REQ-013 SHALL have port redirect_i, input, 1, pipeline flush; restore the speculative state to the committed state.

Function
REQ-014 SHALL keep the storage array, plus a speculative pointer/count (spec_ptr, spec_cnt) and a committed pointer/count (com_ptr, com_cnt); pointers are log2(Depth) bits, counts are 0..Depth.
REQ-015 SHALL derive link = pred_pc_i + 2 when pred_compressed_i = 1, else pred_pc_i + 4, modulo 2^AddrLen.
REQ-016 SHALL, on pred_valid_i with BRANCH_CALL: write link to entry spec_ptr+1, increment spec_ptr, and increment spec_cnt saturating at Depth.
REQ-017 SHALL, on pred_valid_i with BRANCH_RET and spec_cnt > 0: decrement spec_ptr and decrement spec_cnt.
REQ-018 SHALL, on pred_valid_i with BRANCH_RET and spec_cnt = 0: make no state change (underflow ignored).
REQ-019 SHALL, on pred_valid_i with BRANCH_YIELD: overwrite entry spec_ptr with link and leave pointer and count unchanged; if spec_cnt = 0, set spec_cnt to 1.
REQ-020 SHALL ignore all other branch types and make no change when pred_valid_i = 0.
REQ-021 SHALL drive ret_addr_o = entry[spec_ptr] and ret_valid_o = (spec_cnt != 0) combinationally from the registered state; a push or pop becomes visible the cycle after it occurs.
REQ-022 SHALL, on overflow (push at spec_cnt = Depth), wrap the pointer and overwrite the oldest entry.
REQ-023 SHALL apply the same pointer/count arithmetic to com_ptr/com_cnt on commit_valid_i using commit_branch_type_i; the commit path never writes the array.
REQ-024 SHALL, on redirect_i, set spec_ptr/spec_cnt to the next-cycle committed values, so a same-cycle commit is included; pred_valid_i is ignored in that cycle.
REQ-025 SHALL NOT repair entries overwritten by wrong-path pushes; a restored stack may return stale targets (accepted mispredict source).

Reset
REQ-026 SHALL, while rst_ni = 0, clear all pointers, counts and entries to 0, giving ret_valid_o = 0 and ret_addr_o = 0.
REQ-027 SHALL, on reset deassertion mid-operation, start from the empty state with no pending restore.

Structure
REQ-028 SHALL take branch_type_e from muntjac_pkg; no new package types are needed.
REQ-029 SHALL place the pointer/count update in a single function used by both the speculative and committed paths; no sub-module.
REQ-030 SHALL implement storage as flops; Depth is small, so no RAM macro is used.

Verification
REQ-031 SHALL cover: CALL at pc 0x1000 (4-byte), next cycle -> ret_valid_o = 1, ret_addr_o = 0x1004; then RET -> ret_valid_o = 0.
REQ-032 SHALL cover: compressed CALL at 0x2002 -> ret_addr_o = 0x2004.
REQ-033 SHALL cover: Depth+1 calls at pcs 0x0, 0x10, ... -> spec_cnt = Depth; Depth pops return 0x10·k+4 in LIFO order down to the second call; the first call's entry is lost.
REQ-034 SHALL cover: RET on an empty stack -> no state change, ret_valid_o stays 0.
REQ-035 SHALL cover: commit 1 CALL, then speculate 2 more CALLs, then redirect_i -> ret_valid_o = 1 with count 1 and the committed-level target.
REQ-036 SHALL cover: redirect_i and commit_valid_i (CALL) in the same cycle, together with pred_valid_i (RET) -> spec_cnt = com_cnt + 1, and the pred is ignored.

Source files
------------

// File: rtl/muntjac_pkg.sv
// Shared types for the muntjac front end; the RAS consumes the BTB branch classification.
package muntjac_pkg;

  typedef enum logic [2:0] {
    BRANCH_NONE    = 3'd0,
    BRANCH_JUMP    = 3'd1,
    BRANCH_CALL    = 3'd2,
    BRANCH_RET     = 3'd3,
    BRANCH_YIELD   = 3'd4,
    BRANCH_UNTAKEN = 3'd5
  } branch_type_e;

endpackage

// File: rtl/muntjac_ras.sv
// Return address stack with a speculative top (fetch predictions) and a committed
// top (retirement) that the speculative view is restored to on a pipeline flush.
module muntjac_ras
  import muntjac_pkg::*;
#(
  parameter int unsigned AddrLen = 64,
  parameter int unsigned Depth   = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               pred_valid_i,
  input  branch_type_e       pred_branch_type_i,
  input  logic [AddrLen-1:0] pred_pc_i,
  input  logic               pred_compressed_i,
  output logic               ret_valid_o,
  output logic [AddrLen-1:0] ret_addr_o,
  input  logic               commit_valid_i,
  input  branch_type_e       commit_branch_type_i,
  input  logic               redirect_i
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef struct packed {
    logic [PtrW-1:0] ptr;
    logic [CntW-1:0] cnt;
  } stk_t;

  // Pointer/count arithmetic shared by the speculative and committed tops.
  function automatic stk_t stk_update(input logic [PtrW-1:0] ptr,
                                      input logic [CntW-1:0] cnt,
                                      input branch_type_e    btype);
    stk_t r;
    r.ptr = ptr;
    r.cnt = cnt;
    unique case (btype)
      BRANCH_CALL: begin
        r.ptr = PtrW'(ptr + 1'b1);
        if (cnt != CntW'(Depth)) r.cnt = CntW'(cnt + 1'b1);
      end
      BRANCH_RET: begin
        if (cnt != '0) begin
          r.ptr = PtrW'(ptr - 1'b1);
          r.cnt = CntW'(cnt - 1'b1);
        end
      end
      BRANCH_YIELD: begin
        if (cnt == '0) r.cnt = CntW'(1);
      end
      default: ;
    endcase
    return r;
  endfunction

  logic [AddrLen-1:0] entries [Depth];
  logic [PtrW-1:0]    spec_ptr, com_ptr;
  logic [CntW-1:0]    spec_cnt, com_cnt;

  stk_t               spec_nxt, com_nxt;
  logic [AddrLen-1:0] link;
  logic               wr_en;
  logic [PtrW-1:0]    wr_idx;

  always_comb begin
    link     = pred_compressed_i ? AddrLen'(pred_pc_i + AddrLen'(2))
                                 : AddrLen'(pred_pc_i + AddrLen'(4));
    com_nxt  = '{ptr: com_ptr, cnt: com_cnt};
    spec_nxt = '{ptr: spec_ptr, cnt: spec_cnt};
    wr_en    = 1'b0;
    wr_idx   = spec_ptr;

    if (commit_valid_i) com_nxt = stk_update(com_ptr, com_cnt, commit_branch_type_i);

    // A flush takes the committed view including this cycle's retirement.
    if (redirect_i) begin
      spec_nxt = com_nxt;
    end else if (pred_valid_i) begin
      spec_nxt = stk_update(spec_ptr, spec_cnt, pred_branch_type_i);
      if (pred_branch_type_i == BRANCH_CALL) begin
        wr_en  = 1'b1;
        wr_idx = PtrW'(spec_ptr + 1'b1);
      end else if (pred_branch_type_i == BRANCH_YIELD) begin
        wr_en  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spec_ptr <= '0;
      spec_cnt <= '0;
      com_ptr  <= '0;
      com_cnt  <= '0;
    end else begin
      spec_ptr <= spec_nxt.ptr;
      spec_cnt <= spec_nxt.cnt;
      com_ptr  <= com_nxt.ptr;
      com_cnt  <= com_nxt.cnt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) entries[i] <= '0;
    end else if (wr_en) begin
      entries[wr_idx] <= link;
    end
  end

  assign ret_valid_o = (spec_cnt != '0);
  assign ret_addr_o  = entries[spec_ptr];

endmodule

// File: tb/tb_muntjac_ras.sv
// Directed bench for muntjac_ras: expected top-of-stack state is queued per step and
// checked after the clock edge that applies it.
module tb_muntjac_ras;
  import muntjac_pkg::*;

  localparam int unsigned AddrLen = 64;
  localparam int unsigned Depth   = 8;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               pred_valid_i;
  branch_type_e       pred_branch_type_i;
  logic [AddrLen-1:0] pred_pc_i;
  logic               pred_compressed_i;
  logic               ret_valid_o;
  logic [AddrLen-1:0] ret_addr_o;
  logic               commit_valid_i;
  branch_type_e       commit_branch_type_i;
  logic               redirect_i;

  muntjac_ras #(.AddrLen(AddrLen), .Depth(Depth)) dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .pred_valid_i         (pred_valid_i),
    .pred_branch_type_i   (pred_branch_type_i),
    .pred_pc_i            (pred_pc_i),
    .pred_compressed_i    (pred_compressed_i),
    .ret_valid_o          (ret_valid_o),
    .ret_addr_o           (ret_addr_o),
    .commit_valid_i       (commit_valid_i),
    .commit_branch_type_i (commit_branch_type_i),
    .redirect_i           (redirect_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string              tag;
    logic               v;
    logic [AddrLen-1:0] a;
    int                 c;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic check_top();
    exp_t e;
    int   cnt_obs;
    e = exp_q.pop_front();
    cnt_obs = 32'(dut.spec_cnt);
    checks++;
    assert (ret_valid_o === e.v) else begin
      fails++;
      $error("FAIL %s valid: got %0b want %0b", e.tag, ret_valid_o, e.v);
    end
    checks++;
    assert (ret_addr_o === e.a) else begin
      fails++;
      $error("FAIL %s addr: got 0x%0h want 0x%0h", e.tag, ret_addr_o, e.a);
    end
    checks++;
    assert (cnt_obs === e.c) else begin
      fails++;
      $error("FAIL %s count: got %0d want %0d", e.tag, cnt_obs, e.c);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge state, then check it.
  task automatic step(input string tag,
                      input logic pv, input branch_type_e pt,
                      input logic [AddrLen-1:0] pc, input logic comp,
                      input logic cv, input branch_type_e ct, input logic redir,
                      input logic ev, input logic [AddrLen-1:0] ea, input int ec);
    exp_t e;
    pred_valid_i         = pv;
    pred_branch_type_i   = pt;
    pred_pc_i            = pc;
    pred_compressed_i    = comp;
    commit_valid_i       = cv;
    commit_branch_type_i = ct;
    redirect_i           = redir;
    e.tag = tag; e.v = ev; e.a = ea; e.c = ec;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    check_top();
  endtask

  task automatic pred(input string tag, input branch_type_e pt,
                      input logic [AddrLen-1:0] pc, input logic comp,
                      input logic ev, input logic [AddrLen-1:0] ea, input int ec);
    step(tag, 1'b1, pt, pc, comp, 1'b0, BRANCH_NONE, 1'b0, ev, ea, ec);
  endtask

  initial begin
    exp_t e;
    rst_ni = 1'b0;
    pred_valid_i = 1'b0; pred_branch_type_i = BRANCH_NONE; pred_pc_i = '0;
    pred_compressed_i = 1'b0; commit_valid_i = 1'b0;
    commit_branch_type_i = BRANCH_NONE; redirect_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    e.tag = "reset"; e.v = 1'b0; e.a = '0; e.c = 0;
    exp_q.push_back(e);
    check_top();
    rst_ni = 1'b1;
    @(negedge clk_i);

    pred("call_1000", BRANCH_CALL, 64'h1000, 1'b0, 1'b1, 64'h1004, 1);
    pred("ret_1000",  BRANCH_RET,  64'h1050, 1'b0, 1'b0, 64'h0, 0);
    pred("ccall_2002", BRANCH_CALL, 64'h2002, 1'b1, 1'b1, 64'h2004, 1);
    pred("ret_2002",  BRANCH_RET,  64'h2100, 1'b0, 1'b0, 64'h0, 0);
    pred("ret_empty", BRANCH_RET,  64'h2200, 1'b0, 1'b0, 64'h0, 0);

    // Depth+1 calls: the ninth wraps onto the first call's slot.
    for (int k = 0; k <= int'(Depth); k++)
      pred($sformatf("ovf_call%0d", k), BRANCH_CALL, 64'(k * 16), 1'b0,
           1'b1, 64'(k * 16 + 4), (k + 1 > int'(Depth)) ? int'(Depth) : k + 1);
    for (int j = 1; j < int'(Depth); j++)
      pred($sformatf("ovf_pop%0d", j), BRANCH_RET, 64'h0, 1'b0,
           1'b1, 64'((8 - j) * 16 + 4), int'(Depth) - j);
    pred("ovf_pop8", BRANCH_RET, 64'h0, 1'b0, 1'b0, 64'h84, 0);

    // Resync speculative pointer to the (empty) committed state: slot 0 holds call 7.
    step("resync", 1'b0, BRANCH_NONE, 64'h0, 1'b0, 1'b0, BRANCH_NONE, 1'b1,
         1'b0, 64'h74, 0);

    step("com_call", 1'b1, BRANCH_CALL, 64'h3000, 1'b0, 1'b1, BRANCH_CALL, 1'b0,
         1'b1, 64'h3004, 1);
    pred("spec_call_a", BRANCH_CALL, 64'h4000, 1'b0, 1'b1, 64'h4004, 2);
    pred("spec_call_b", BRANCH_CALL, 64'h5000, 1'b0, 1'b1, 64'h5004, 3);
    step("redirect", 1'b0, BRANCH_NONE, 64'h0, 1'b0, 1'b0, BRANCH_NONE, 1'b1,
         1'b1, 64'h3004, 1);

    // Flush with same-cycle commit; the RET prediction must be dropped.
    step("redir_commit", 1'b1, BRANCH_RET, 64'h7777, 1'b0, 1'b1, BRANCH_CALL, 1'b1,
         1'b1, 64'h4004, 2);

    pred("yield", BRANCH_YIELD, 64'h6000, 1'b0, 1'b1, 64'h6004, 2);
    pred("jump_ign", BRANCH_JUMP, 64'h9000, 1'b0, 1'b1, 64'h6004, 2);
    step("pred_idle", 1'b0, BRANCH_CALL, 64'hA000, 1'b0, 1'b0, BRANCH_NONE, 1'b0,
         1'b1, 64'h6004, 2);

    // Mid-operation reset.
    pred_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    e.tag = "rst_mid"; e.v = 1'b0; e.a = '0; e.c = 0;
    exp_q.push_back(e);
    check_top();
    @(negedge clk_i);
    rst_ni = 1'b1;
    step("post_rst", 1'b0, BRANCH_NONE, 64'h0, 1'b0, 1'b0, BRANCH_NONE, 1'b0,
         1'b0, 64'h0, 0);
    pred("yield_empty", BRANCH_YIELD, 64'h7000, 1'b1, 1'b1, 64'h7002, 1);
    pred("call_after", BRANCH_CALL, 64'h8000, 1'b1, 1'b1, 64'h8002, 2);
    pred("ret_after", BRANCH_RET, 64'h0, 1'b0, 1'b1, 64'h7002, 1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
